afc_freq_comparator: RTL and testbench
======================================

Name: afc_freq_comparator

Overview:
Measurement end of the AFC loop. On each `reset_counters` pulse from the binary-search controller, it counts rising edges of the divided VCO signal over a fixed window of `clk` cycles. It then compares the count against a programmed target with a ± tolerance and drives the `gt_flag`, `lt_flag` and `eq_flag` verdicts back to the controller. The result is held until the next `reset_counters`.

Parameters:
- CNT_WIDTH, 8: width of the VCO edge counter, `target_count`, `tolerance` and `meas_count`.
- WINDOW_CYCLES, 64: measurement window in `clk` cycles. Must be ≥ 2 and less than the controller settle time (100) so the flags are valid before the controller samples them.
- WIN_WIDTH, 7: width of the window counter. Must satisfy 2^WIN_WIDTH > WINDOW_CYCLES.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-high reset.
- reset_counters, input, 1: single-cycle start/restart pulse from the controller.
- vco_in, input, 1: divided VCO signal, already synchronous to `clk`.
- target_count, input, CNT_WIDTH: expected edge count per window. Captured on `reset_counters`.
- tolerance, input, CNT_WIDTH: allowed ± deviation. Captured on `reset_counters`.
- gt_flag, output, 1: target exceeds the measurement; the code must increase.
- lt_flag, output, 1: measurement exceeds the target; the code must decrease.
- eq_flag, output, 1: measurement is within tolerance.
- meas_valid, output, 1: flags and `meas_count` hold a completed measurement.
- meas_count, output, CNT_WIDTH: edge count of the last completed window.

Behaviour:
- Reset (`rst`=1, asynchronous):
  - State goes to IDLE.
  - All counters, captured target and tolerance, `vco_prev`, `gt_flag`, `lt_flag`, `eq_flag`, `meas_valid` and `meas_count` go to 0.
- Edge detection:
  - `vco_prev` is registered from `vco_in` on every cycle, in every state.
  - A rising edge is `vco_in & ~vco_prev`.
- States: IDLE, COUNT, EVAL, HOLD.
  - IDLE: outputs stay 0. Waits for `reset_counters`.
  - Any state, on an edge where `reset_counters`=1 (highest priority):
    - Window counter and edge counter go to 0.
    - `target_count` and `tolerance` are captured.
    - All flags, `meas_valid` and `meas_count` go to 0.
    - State goes to COUNT.
  - COUNT:
    - On each edge, the window counter increments.
    - The edge counter increments if a rising edge is detected, saturating at all-ones with no wrap.
    - On the edge where the window counter equals WINDOW_CYCLES-1, the final increment is applied and the state goes to EVAL.
  - EVAL (one cycle): the verdict is registered.
    - upper = target + tol, computed at CNT_WIDTH+1 bits with no overflow.
    - lower = target − tol, saturating at 0.
    - `gt_flag` = (count < lower).
    - `lt_flag` = (count > upper).
    - `eq_flag` = neither.
    - `meas_count` = count. `meas_valid` = 1. State goes to HOLD.
  - HOLD: all outputs are held stable until `reset_counters` or `rst`.
- Latency: if `reset_counters` is sampled at edge T, the outputs are valid after edge T+WINDOW_CYCLES+1 (edge T+65 at the default setting).
- Invariant: when `meas_valid`=1, exactly one of `gt_flag`, `lt_flag`, `eq_flag` is 1. When `meas_valid`=0, all three are 0.
- Boundary conditions:
  - `reset_counters` during COUNT or EVAL aborts the window, restarts it, and produces no verdict for the aborted window.
  - `reset_counters` on the same edge as the EVAL transition: the restart wins and the flags stay 0.
  - `tolerance` ≥ `target_count`: lower = 0, so `gt_flag` can never be asserted.
  - target + tol > 2^CNT_WIDTH−1: upper exceeds the maximum count, so `lt_flag` can never be asserted.
  - Changes to `target_count` or `tolerance` after capture have no effect until the next `reset_counters`.
  - A `vco_in` rising edge on the restart edge itself is not counted.

Decomposition:
- Package `afc_pkg`:
  - state encoding localparams (IDLE, COUNT, EVAL, HOLD);
  - default CNT_WIDTH, WINDOW_CYCLES and WIN_WIDTH;
  - the shared AFC settle-cycle constant (100), so the WINDOW_CYCLES < settle-cycle check lives in one place.
- Sub-module `afc_edge_counter` (natural split):
  - contains the edge detector and the saturating CNT_WIDTH counter;
  - ports: `clk`, `rst`, `clr`, `en`, `sig_in`, `count`.

Test Plan:
1. `vco_in` high for 1 of every 2 cycles, target=32, tol=0, pulse `reset_counters` → `meas_valid`=1 exactly 65 cycles later, `meas_count`=32, `eq_flag`=1, `gt_flag`=`lt_flag`=0.
2. Same stimulus, target=40, tol=2 → `gt_flag`=1 (32 < 38). Then target=20, tol=4 with a new pulse → `lt_flag`=1 (32 > 24), and the flags read 0 during the new window.
3. Pulse `reset_counters` at window cycle 30, then again at cycle 64 of the second window (the EVAL edge) → no verdict from the first window, flags stay 0 through the restart, and only the third window reports `meas_count`=32.
4. CNT_WIDTH=4, `vco_in` high 1 cycle in 2 (32 edges), target=15, tol=0 → `meas_count`=15 (saturated, no wrap), `eq_flag`=1. Then target=3, tol=5 → lower clamps to 0, `lt_flag`=1.
5. Assert `rst` asynchronously mid-COUNT, between clock edges → all outputs go to 0 immediately and the state is IDLE. With no `reset_counters` afterwards, outputs stay 0 for 200 cycles.
6. After a verdict, toggle `target_count` and `tolerance` while in HOLD → flags and `meas_count` remain unchanged.

Source files
------------

// File: rtl/afc_pkg.sv
// Shared constants and state encoding for the AFC frequency comparator.
package afc_pkg;

  localparam int AFC_CNT_WIDTH     = 8;
  localparam int AFC_WINDOW_CYCLES = 64;
  localparam int AFC_WIN_WIDTH     = 7;
  // Controller waits this many cycles before sampling the verdict flags.
  localparam int AFC_SETTLE_CYCLES = 100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_EVAL  = 2'd2,
    ST_HOLD  = 2'd3
  } afc_state_e;

endpackage

// File: rtl/afc_edge_counter.sv
// Rising-edge detector feeding a saturating edge counter.
module afc_edge_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         sig_in,
  output logic [W-1:0] count
);

  logic sig_prev;
  logic rise;

  assign rise = sig_in & ~sig_prev;

  // The previous-sample register runs every cycle so an edge straddling a
  // restart is judged against the true prior level; clr still wins on that edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_prev <= 1'b0;
      count    <= '0;
    end else begin
      sig_prev <= sig_in;
      if (clr) begin
        count <= '0;
      end else if (en && rise && (count != '1)) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/afc_freq_comparator.sv
// Counts VCO rising edges over a fixed clk window and reports a
// greater/less/equal verdict against a captured target and tolerance.
module afc_freq_comparator
  import afc_pkg::*;
#(
  parameter int CNT_WIDTH     = AFC_CNT_WIDTH,
  parameter int WINDOW_CYCLES = AFC_WINDOW_CYCLES,
  parameter int WIN_WIDTH     = AFC_WIN_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 reset_counters,
  input  logic                 vco_in,
  input  logic [CNT_WIDTH-1:0] target_count,
  input  logic [CNT_WIDTH-1:0] tolerance,
  output logic                 gt_flag,
  output logic                 lt_flag,
  output logic                 eq_flag,
  output logic                 meas_valid,
  output logic [CNT_WIDTH-1:0] meas_count,
  output logic [1:0]           fsm_state
);

  if (WINDOW_CYCLES < 2 || WINDOW_CYCLES >= AFC_SETTLE_CYCLES ||
      (1 << WIN_WIDTH) <= WINDOW_CYCLES) begin : g_bad_params
    $error("afc_freq_comparator: illegal WINDOW_CYCLES/WIN_WIDTH");
  end

  localparam logic [WIN_WIDTH-1:0] WIN_LAST = WIN_WIDTH'(WINDOW_CYCLES - 1);

  afc_state_e           state;
  logic [WIN_WIDTH-1:0] win_cnt;
  logic [CNT_WIDTH-1:0] edge_cnt;
  logic [CNT_WIDTH-1:0] target_q;
  logic [CNT_WIDTH-1:0] tol_q;
  logic [CNT_WIDTH:0]   upper;
  logic [CNT_WIDTH:0]   lower;
  logic [CNT_WIDTH:0]   count_ext;
  logic                 below;
  logic                 above;

  assign fsm_state = state;

  // One extra bit keeps target+tol from wrapping; lower clamps at zero.
  assign upper     = {1'b0, target_q} + {1'b0, tol_q};
  assign lower     = (target_q >= tol_q) ? {1'b0, target_q - tol_q} : '0;
  assign count_ext = {1'b0, edge_cnt};
  assign below     = count_ext < lower;
  assign above     = count_ext > upper;

  afc_edge_counter #(
    .W (CNT_WIDTH)
  ) u_edge_counter (
    .clk    (clk),
    .rst    (rst),
    .clr    (reset_counters),
    .en     (state == ST_COUNT),
    .sig_in (vco_in),
    .count  (edge_cnt)
  );

  // Handshake: reset_counters is a one-cycle start pulse with no back-pressure;
  // it restarts from any state, and meas_valid stays high until the next pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      win_cnt    <= '0;
      target_q   <= '0;
      tol_q      <= '0;
      gt_flag    <= 1'b0;
      lt_flag    <= 1'b0;
      eq_flag    <= 1'b0;
      meas_valid <= 1'b0;
      meas_count <= '0;
    end else if (reset_counters) begin
      state      <= ST_COUNT;
      win_cnt    <= '0;
      target_q   <= target_count;
      tol_q      <= tolerance;
      gt_flag    <= 1'b0;
      lt_flag    <= 1'b0;
      eq_flag    <= 1'b0;
      meas_valid <= 1'b0;
      meas_count <= '0;
    end else begin
      case (state)
        ST_IDLE: state <= ST_IDLE;
        ST_COUNT: begin
          win_cnt <= win_cnt + 1'b1;
          if (win_cnt == WIN_LAST) begin
            state <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          gt_flag    <= below;
          lt_flag    <= above;
          eq_flag    <= !below && !above;
          meas_count <= edge_cnt;
          meas_valid <= 1'b1;
          state      <= ST_HOLD;
        end
        ST_HOLD: state <= ST_HOLD;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_afc_freq_comparator.sv
// Directed bench for afc_freq_comparator: default instance plus a 4-bit
// counter instance for saturation behaviour.
module tb_afc_freq_comparator;

  logic       clk = 1'b0;
  logic       rst;
  logic       rc;
  logic       rc4;
  logic       vco_in;
  logic       vco_run;
  logic [7:0] target;
  logic [7:0] tol;
  logic [3:0] target4;
  logic [3:0] tol4;

  logic       gt, lt, eq, valid;
  logic [7:0] mcount;
  logic [1:0] st;
  logic       gt4, lt4, eq4, valid4;
  logic [3:0] mcount4;
  logic [1:0] st4;
  logic [3:0] v;
  logic [3:0] v4;

  int checks = 0;
  int errors = 0;

  assign v  = {valid, gt, lt, eq};
  assign v4 = {valid4, gt4, lt4, eq4};

  afc_freq_comparator dut (
    .clk            (clk),
    .rst            (rst),
    .reset_counters (rc),
    .vco_in         (vco_in),
    .target_count   (target),
    .tolerance      (tol),
    .gt_flag        (gt),
    .lt_flag        (lt),
    .eq_flag        (eq),
    .meas_valid     (valid),
    .meas_count     (mcount),
    .fsm_state      (st)
  );

  afc_freq_comparator #(
    .CNT_WIDTH (4)
  ) dut4 (
    .clk            (clk),
    .rst            (rst),
    .reset_counters (rc4),
    .vco_in         (vco_in),
    .target_count   (target4),
    .tolerance      (tol4),
    .gt_flag        (gt4),
    .lt_flag        (lt4),
    .eq_flag        (eq4),
    .meas_valid     (valid4),
    .meas_count     (mcount4),
    .fsm_state      (st4)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // VCO stimulus: toggles every cycle, giving one rising edge per two cycles.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (vco_run) vco_in = ~vco_in;
    end
  end

  task automatic pulse(input bit sel4);
    @(posedge clk);
    #1;
    if (sel4) rc4 = 1'b1;
    else rc = 1'b1;
    @(posedge clk);
    #1;
    rc  = 1'b0;
    rc4 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; rc = 1'b0; rc4 = 1'b0; vco_in = 1'b0; vco_run = 1'b0;
    target = '0; tol = '0; target4 = '0; tol4 = '0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (v !== 4'b0000 || mcount !== 8'd0 || st !== 2'd0) begin
      errors++;
      $display("FAIL reset_dut: got v=%b cnt=%0d st=%0d want v=0000 cnt=0 st=0", v, mcount, st);
    end
    checks++;
    if (v4 !== 4'b0000 || mcount4 !== 4'd0 || st4 !== 2'd0) begin
      errors++;
      $display("FAIL reset_dut4: got v=%b cnt=%0d st=%0d want v=0000 cnt=0 st=0", v4, mcount4, st4);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    vco_run = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (v !== 4'b0000 || st !== 2'd0) begin
      errors++;
      $display("FAIL idle_quiet: got v=%b st=%0d want v=0000 st=0", v, st);
    end
  endtask

  task automatic test_eq_latency();
    target = 8'd32; tol = 8'd0;
    pulse(1'b0);
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (v !== 4'b0000 || st !== 2'd1) begin
      errors++;
      $display("FAIL eq_midwindow: got v=%b st=%0d want v=0000 st=1", v, st);
    end
    repeat (34) @(posedge clk);
    #1;
    checks++;
    if (v !== 4'b0000) begin
      errors++;
      $display("FAIL eq_early: got v=%b at T+64 want 0000", v);
    end
    @(posedge clk);
    #1;
    checks++;
    if (v !== 4'b1001 || mcount !== 8'd32) begin
      errors++;
      $display("FAIL eq_verdict: got v=%b cnt=%0d want v=1001 cnt=32", v, mcount);
    end
  endtask

  task automatic test_gt_lt();
    target = 8'd40; tol = 8'd2;
    pulse(1'b0);
    target = 8'd0; tol = 8'd0;
    repeat (65) @(posedge clk);
    #1;
    checks++;
    if (v !== 4'b1100 || mcount !== 8'd32) begin
      errors++;
      $display("FAIL gt_verdict: got v=%b cnt=%0d want v=1100 cnt=32", v, mcount);
    end
    target = 8'd20; tol = 8'd4;
    pulse(1'b0);
    checks++;
    if (v !== 4'b0000 || mcount !== 8'd0) begin
      errors++;
      $display("FAIL lt_cleared: got v=%b cnt=%0d want v=0000 cnt=0", v, mcount);
    end
    repeat (65) @(posedge clk);
    #1;
    checks++;
    if (v !== 4'b1010 || mcount !== 8'd32) begin
      errors++;
      $display("FAIL lt_verdict: got v=%b cnt=%0d want v=1010 cnt=32", v, mcount);
    end
  endtask

  task automatic test_abort();
    target = 8'd32; tol = 8'd0;
    pulse(1'b0);
    repeat (30) @(posedge clk);
    #1 rc = 1'b1;
    @(posedge clk);
    #1 rc = 1'b0;
    checks++;
    if (v !== 4'b0000 || st !== 2'd1) begin
      errors++;
      $display("FAIL abort_restart: got v=%b st=%0d want v=0000 st=1", v, st);
    end
    repeat (64) @(posedge clk);
    #1;
    checks++;
    if (v !== 4'b0000 || st !== 2'd2) begin
      errors++;
      $display("FAIL abort_at_eval: got v=%b st=%0d want v=0000 st=2", v, st);
    end
    rc = 1'b1;
    @(posedge clk);
    #1 rc = 1'b0;
    checks++;
    if (v !== 4'b0000 || st !== 2'd1) begin
      errors++;
      $display("FAIL abort_eval_wins: got v=%b st=%0d want v=0000 st=1", v, st);
    end
    repeat (64) @(posedge clk);
    #1;
    checks++;
    if (v !== 4'b0000) begin
      errors++;
      $display("FAIL abort_third_early: got v=%b want 0000", v);
    end
    @(posedge clk);
    #1;
    checks++;
    if (v !== 4'b1001 || mcount !== 8'd32) begin
      errors++;
      $display("FAIL abort_third_verdict: got v=%b cnt=%0d want v=1001 cnt=32", v, mcount);
    end
  endtask

  task automatic test_saturate();
    target4 = 4'd15; tol4 = 4'd0;
    pulse(1'b1);
    repeat (65) @(posedge clk);
    #1;
    checks++;
    if (v4 !== 4'b1001 || mcount4 !== 4'd15) begin
      errors++;
      $display("FAIL sat_eq: got v=%b cnt=%0d want v=1001 cnt=15", v4, mcount4);
    end
    target4 = 4'd3; tol4 = 4'd5;
    pulse(1'b1);
    repeat (65) @(posedge clk);
    #1;
    checks++;
    if (v4 !== 4'b1010 || mcount4 !== 4'd15) begin
      errors++;
      $display("FAIL sat_lt: got v=%b cnt=%0d want v=1010 cnt=15", v4, mcount4);
    end
  endtask

  task automatic test_tol_bounds();
    // tol > target: lower clamps to 0, upper 30, count 32 -> lt
    target = 8'd10; tol = 8'd20;
    pulse(1'b0);
    repeat (65) @(posedge clk);
    #1;
    checks++;
    if (v !== 4'b1010) begin
      errors++;
      $display("FAIL tol_clamp_lt: got v=%b want 1010", v);
    end
    // target+tol = 270 must not wrap to 14
    target = 8'd30; tol = 8'd240;
    pulse(1'b0);
    repeat (65) @(posedge clk);
    #1;
    checks++;
    if (v !== 4'b1001) begin
      errors++;
      $display("FAIL tol_upper_wide: got v=%b want 1001", v);
    end
    // lower = 240, count 32 -> gt
    target = 8'd250; tol = 8'd10;
    pulse(1'b0);
    repeat (65) @(posedge clk);
    #1;
    checks++;
    if (v !== 4'b1100) begin
      errors++;
      $display("FAIL tol_high_gt: got v=%b want 1100", v);
    end
  endtask

  task automatic test_restart_edge();
    vco_run = 1'b0;
    @(posedge clk);
    #2 vco_in = 1'b0;
    target = 8'd0; tol = 8'd0;
    @(posedge clk);
    #1 rc = 1'b1;
    vco_in = 1'b1;
    @(posedge clk);
    #1 rc = 1'b0;
    repeat (65) @(posedge clk);
    #1;
    checks++;
    if (v !== 4'b1001 || mcount !== 8'd0) begin
      errors++;
      $display("FAIL restart_edge: got v=%b cnt=%0d want v=1001 cnt=0", v, mcount);
    end
    vco_run = 1'b1;
  endtask

  task automatic test_async_reset();
    int bad;
    target = 8'd32; tol = 8'd0;
    pulse(1'b0);
    repeat (65) @(posedge clk);
    #1;
    checks++;
    if (v !== 4'b1001 || mcount !== 8'd32) begin
      errors++;
      $display("FAIL rst_pre_verdict: got v=%b cnt=%0d want v=1001 cnt=32", v, mcount);
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (v !== 4'b0000 || mcount !== 8'd0 || st !== 2'd0) begin
      errors++;
      $display("FAIL rst_hold_async: got v=%b cnt=%0d st=%0d want v=0000 cnt=0 st=0", v, mcount, st);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    pulse(1'b0);
    repeat (20) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (v !== 4'b0000 || mcount !== 8'd0 || st !== 2'd0) begin
      errors++;
      $display("FAIL rst_count_async: got v=%b cnt=%0d st=%0d want v=0000 cnt=0 st=0", v, mcount, st);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (v !== 4'b0000 || mcount !== 8'd0 || st !== 2'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rst_stay_idle: got %0d non-idle cycles want 0 (last v=%b st=%0d)", bad, v, st);
    end
  endtask

  task automatic test_hold_stable();
    int bad;
    target = 8'd32; tol = 8'd0;
    pulse(1'b0);
    repeat (65) @(posedge clk);
    #1;
    checks++;
    if (v !== 4'b1001 || mcount !== 8'd32) begin
      errors++;
      $display("FAIL hold_initial: got v=%b cnt=%0d want v=1001 cnt=32", v, mcount);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      target = ~target;
      tol    = tol + 8'd13;
      @(posedge clk);
      #1;
      if (v !== 4'b1001 || mcount !== 8'd32 || st !== 2'd3) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_stable: got %0d changed cycles want 0 (last v=%b cnt=%0d)", bad, v, mcount);
    end
  endtask

  initial begin
    test_reset();
    test_eq_latency();
    test_gt_lt();
    test_abort();
    test_saturate();
    test_tol_bounds();
    test_restart_edge();
    test_async_reset();
    test_hold_stable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
